als_sample_averager: RTL and testbench
======================================

ALS_SAMPLE_AVERAGER -- requirements
Module: als_sample_averager

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 3, log2 of samples per average (2^3 = 8); legal range 0..4.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, clk cycles o_Start may stay high before abandoning the conversion.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_RX_Byte  input  8  light byte from the SPI receive stage, valid when i_RX_DV=1.
REQ-006 SHALL have port i_RX_DV  input  1  one-cycle strobe, new byte on i_RX_Byte (clk domain).
REQ-007 SHALL have port i_Conv_Done  input  1  double-dabble done flag (o_DV), synchronous to clk; level or pulse.
REQ-008 SHALL have port o_Binary  output  8  last published average; feeds double-dabble i_Binary.
REQ-009 SHALL have port o_Start  output  1  conversion request to double dabble; held until done or timeout.
REQ-010 SHALL have port o_Valid  output  1  one-cycle pulse, o_Binary updated this cycle.
REQ-011 SHALL have port o_Timeout  output  1  sticky, a conversion was abandoned.
REQ-012 SHALL have port o_Overrun  output  1  sticky, a batch completed while a conversion was pending and was discarded.

Function
REQ-013 SHALL implement states ACCUM and CONVERT; reset state ACCUM.
REQ-014 SHALL, in any state, on i_RX_DV add i_RX_Byte to an accumulator of width 8+AVG_LOG2 and increment a sample counter of width AVG_LOG2 (wraps).
REQ-015 SHALL treat the i_RX_DV cycle where the counter equals 2^AVG_LOG2-1 as batch completion: sum = acc + i_RX_Byte; acc and counter clear to 0 that edge; no sample lost.
REQ-016 SHALL, on batch completion in ACCUM, load o_Binary = sum >> AVG_LOG2 (truncate, no rounding), pulse o_Valid, enter CONVERT; all three visible the cycle after the final i_RX_DV.
REQ-017 SHALL, on batch completion in CONVERT, leave o_Binary unchanged, not pulse o_Valid, set o_Overrun.
REQ-018 SHALL drive o_Start=1 exactly while in CONVERT (registered).
REQ-019 SHALL detect done as a rising edge of i_Conv_Done (registered prior value); only edges while in CONVERT count; a level high on CONVERT entry is ignored until it falls and rises.
REQ-020 SHALL, on done edge in CONVERT, return to ACCUM the next cycle (o_Start low).
REQ-021 SHALL count CONVERT cycles from 0; on reaching TIMEOUT_CYCLES-1 without done, set o_Timeout, return to ACCUM; counter clears on every CONVERT entry.
REQ-022 SHALL give done-edge priority over timeout in the same cycle (o_Timeout not set).
REQ-023 SHALL never overflow the accumulator: 8 x 0xFF = 0x7F8 fits 11 bits.
REQ-024 SHALL, with AVG_LOG2=0, publish every sample directly (sum = i_RX_Byte).

Reset
REQ-025 SHALL, when rst=1 at a clk edge, set state ACCUM, accumulator 0, sample counter 0, timeout counter 0, done-history 0, o_Binary 0x00, o_Start 0, o_Valid 0, o_Timeout 0, o_Overrun 0.
REQ-026 SHALL give rst priority over i_RX_DV and i_Conv_Done in the same cycle; a partial batch is discarded; mid-CONVERT reset drops o_Start the next cycle.

Structure
REQ-027 SHALL take AVG_LOG2 and TIMEOUT_CYCLES defaults and the state enumeration (ACCUM, CONVERT) from shared package als_pkg.
REQ-028 SHALL instantiate one sub-module, als_edge_detect (clk, rst, level in, one-cycle rise pulse out), for i_Conv_Done.

Verification
REQ-029 SHALL check: 8 strobes of 0x29 spaced 50 cycles -> one cycle after 8th strobe o_Binary=0x29, o_Valid=1 for one cycle, o_Start=1.
REQ-030 SHALL check: bytes 0x00..0x07 (sum 28) -> o_Binary=0x03; then 8 x 0xFF -> o_Binary=0xFF, o_Overrun=0.
REQ-031 SHALL check: in CONVERT, i_Conv_Done held 0 -> o_Start falls after exactly TIMEOUT_CYCLES cycles, o_Timeout=1 and stays 1 through later batches.
REQ-032 SHALL check: o_Start held, 8 more strobes before done -> o_Binary unchanged, no o_Valid, o_Overrun=1; done edge then returns ACCUM with acc=0.
REQ-033 SHALL check: rst after 5 strobes of 0x10, then 8 strobes of 0x20 -> o_Binary=0x20 (pre-reset samples discarded).
REQ-034 SHALL check: i_Conv_Done already high on CONVERT entry -> o_Start stays 1 until i_Conv_Done falls and rises again.

Source files
------------

// File: rtl/als_pkg.sv
// Shared definitions for the ambient-light sample averager.
//   AVG_LOG2_DEF       : default log2 of samples per published average
//   TIMEOUT_CYCLES_DEF : default clk cycles a conversion request may stay open
//   als_state_e        : ACCUM (collecting samples) / CONVERT (waiting on BCD)
package als_pkg;
  localparam int AVG_LOG2_DEF       = 3;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic {
    ACCUM   = 1'b0,
    CONVERT = 1'b1
  } als_state_e;
endpackage

// File: rtl/als_edge_detect.sv
// Rising-edge detector for a clk-synchronous level.
//   clk     : clock
//   rst     : synchronous active-high reset (history cleared to 0)
//   level_i : level to watch
//   rise_o  : high for the single cycle where level_i is 1 and was 0 last cycle
module als_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;
endmodule

// File: rtl/als_sample_averager.sv
// Averages 2^AVG_LOG2 light bytes from the SPI receiver and hands each average
// to the double-dabble converter, holding o_Start until the converter reports
// done (rising edge of i_Conv_Done) or TIMEOUT_CYCLES elapse.
//   clk, rst    : clock, synchronous active-high reset
//   i_RX_Byte   : received light byte, qualified by i_RX_DV
//   i_RX_DV     : one-cycle byte strobe
//   i_Conv_Done : converter done flag (level or pulse)
//   o_Binary    : last published average
//   o_Start     : conversion request, high exactly while in CONVERT
//   o_Valid     : one-cycle pulse when o_Binary is updated
//   o_Timeout   : sticky, a conversion was abandoned
//   o_Overrun   : sticky, a batch completed during CONVERT and was dropped
module als_sample_averager
  import als_pkg::*;
#(
  parameter int AVG_LOG2       = AVG_LOG2_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_RX_DV,
  input  logic       i_Conv_Done,
  output logic [7:0] o_Binary,
  output logic       o_Start,
  output logic       o_Valid,
  output logic       o_Timeout,
  output logic       o_Overrun
);
  localparam int ACC_W = 8 + AVG_LOG2;
  // Counter kept at least 1 bit wide; with AVG_LOG2=0 it is pinned at 0 and
  // every strobe completes a batch.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  als_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       binary_q, binary_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;

  logic             conv_rise;
  logic             batch_done;
  logic             tmo_hit;
  logic [ACC_W-1:0] sum;
  logic [7:0]       avg;

  als_edge_detect u_done_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (i_Conv_Done),
    .rise_o  (conv_rise)
  );

  // The final sample is folded in combinationally so the batch completes on
  // the strobe itself and the accumulator can restart cleanly that edge.
  assign sum        = acc_q + ACC_W'(i_RX_Byte);
  assign avg        = 8'(sum >> AVG_LOG2);
  assign batch_done = i_RX_DV && (cnt_q == CNT_LAST);
  assign tmo_hit    = (tmo_q == TMO_LAST);

  // State register plus all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      binary_q  <= 8'h00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      binary_q  <= binary_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic; a done edge wins over a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (batch_done) state_d = CONVERT;
      CONVERT: if (conv_rise || tmo_hit) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Datapath next values; sampling continues regardless of state
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    binary_d  = binary_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    tmo_d     = '0;

    if (i_RX_DV) begin
      if (batch_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (batch_done) begin
      if (state_q == ACCUM) begin
        binary_d = avg;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Timer runs only while staying in CONVERT, so every entry starts at 0
    if (state_q == CONVERT) begin
      if (!conv_rise && tmo_hit) timeout_d = 1'b1;
      if (state_d == CONVERT)    tmo_d     = tmo_q + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    o_Start   = (state_q == CONVERT);
    o_Binary  = binary_q;
    o_Valid   = valid_q;
    o_Timeout = timeout_q;
    o_Overrun = overrun_q;
  end
endmodule

// File: tb/tb_als_sample_averager.sv
module tb_als_sample_averager;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_RX_Byte;
  logic       i_RX_DV;
  logic       i_Conv_Done;
  logic [7:0] o_Binary,  o_Binary0;
  logic       o_Start,   o_Start0;
  logic       o_Valid,   o_Valid0;
  logic       o_Timeout, o_Timeout0;
  logic       o_Overrun, o_Overrun0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  als_sample_averager u_dut (
    .clk(clk), .rst(rst), .i_RX_Byte(i_RX_Byte), .i_RX_DV(i_RX_DV),
    .i_Conv_Done(i_Conv_Done), .o_Binary(o_Binary), .o_Start(o_Start),
    .o_Valid(o_Valid), .o_Timeout(o_Timeout), .o_Overrun(o_Overrun)
  );

  als_sample_averager #(.AVG_LOG2(0), .TIMEOUT_CYCLES(16)) u_dut0 (
    .clk(clk), .rst(rst), .i_RX_Byte(i_RX_Byte), .i_RX_DV(i_RX_DV),
    .i_Conv_Done(i_Conv_Done), .o_Binary(o_Binary0), .o_Start(o_Start0),
    .o_Valid(o_Valid0), .o_Timeout(o_Timeout0), .o_Overrun(o_Overrun0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One strobe; returns at the negedge after the capturing edge
  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    i_RX_Byte = b;
    i_RX_DV   = 1'b1;
    @(negedge clk);
    i_RX_DV   = 1'b0;
  endtask

  // n strobes of b, gap idle negedges between them (none after the last)
  task automatic batch(input logic [7:0] b, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      strobe(b);
      if (i < n - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    i_Conv_Done = 1'b1;
    @(negedge clk);
    i_Conv_Done = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; i_RX_Byte = 8'h00; i_RX_DV = 1'b0; i_Conv_Done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_binary",  32'(o_Binary),  32'h00);
    chk("rst_start",   32'(o_Start),   32'h0);
    chk("rst_valid",   32'(o_Valid),   32'h0);
    chk("rst_timeout", 32'(o_Timeout), 32'h0);
    chk("rst_overrun", 32'(o_Overrun), 32'h0);
    rst = 1'b0;

    // 8 x 0x29 spaced 50 cycles; the 1-sample instance publishes at once
    for (int i = 0; i < 8; i++) begin
      strobe(8'h29);
      if (i == 0) begin
        chk("avg0_binary", 32'(o_Binary0), 32'h29);
        chk("avg0_valid",  32'(o_Valid0),  32'h1);
        chk("avg0_start",  32'(o_Start0),  32'h1);
        chk("first_novalid", 32'(o_Valid), 32'h0);
      end
      if (i < 7) repeat (48) @(negedge clk);
    end
    chk("b29_binary", 32'(o_Binary), 32'h29);
    chk("b29_valid",  32'(o_Valid),  32'h1);
    chk("b29_start",  32'(o_Start),  32'h1);
    @(negedge clk);
    chk("b29_valid_pulse", 32'(o_Valid), 32'h0);
    chk("b29_start_hold",  32'(o_Start), 32'h1);
    pulse_done();
    chk("b29_done_start", 32'(o_Start), 32'h0);

    // 0..7 -> 28>>3 = 3 ; then all 0xFF -> 0x7F8>>3 = 0xFF
    for (int i = 0; i < 8; i++) strobe(8'(i));
    chk("ramp_binary", 32'(o_Binary), 32'h03);
    pulse_done();
    batch(8'hFF, 8, 1);
    chk("ff_binary",  32'(o_Binary),  32'hFF);
    chk("ff_overrun", 32'(o_Overrun), 32'h0);
    pulse_done();

    // Timeout: o_Start must stay high exactly 4096 cycles
    batch(8'h40, 8, 0);
    chk("tmo_binary", 32'(o_Binary), 32'h40);
    n = 0;
    while (o_Start && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles",  32'(n),         32'd4096);
    chk("tmo_flag",    32'(o_Timeout), 32'h1);
    batch(8'h08, 8, 0);
    chk("tmo_next_binary", 32'(o_Binary),  32'h08);
    chk("tmo_sticky",      32'(o_Timeout), 32'h1);
    pulse_done();
    chk("tmo_sticky2", 32'(o_Timeout), 32'h1);

    // Overrun: batch completes while conversion pending
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("rst2_timeout", 32'(o_Timeout), 32'h0);
    batch(8'h50, 8, 0);
    chk("ovr_first", 32'(o_Binary), 32'h50);
    for (int i = 0; i < 8; i++) begin
      strobe(8'h10);
      chk("ovr_novalid", 32'(o_Valid), 32'h0);
    end
    chk("ovr_binary", 32'(o_Binary),  32'h50);
    chk("ovr_flag",   32'(o_Overrun), 32'h1);
    chk("ovr_start",  32'(o_Start),   32'h1);
    pulse_done();
    chk("ovr_done_start", 32'(o_Start), 32'h0);
    batch(8'h02, 8, 0);
    chk("ovr_acc_clear", 32'(o_Binary), 32'h02);
    pulse_done();

    // Reset discards a partial batch
    batch(8'h10, 5, 0);
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    batch(8'h20, 8, 0);
    chk("rstp_binary", 32'(o_Binary), 32'h20);
    chk("rstp_start",  32'(o_Start),  32'h1);
    // Mid-CONVERT reset drops o_Start next cycle
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("rstc_start",  32'(o_Start),  32'h0);
    chk("rstc_binary", 32'(o_Binary), 32'h00);

    // Done already high on entry is ignored until it falls and rises
    @(negedge clk); i_Conv_Done = 1'b1;
    repeat (2) @(negedge clk);
    batch(8'h33, 8, 1);
    chk("lvl_binary", 32'(o_Binary), 32'h33);
    repeat (10) @(negedge clk);
    chk("lvl_held", 32'(o_Start), 32'h1);
    i_Conv_Done = 1'b0;
    @(negedge clk);
    chk("lvl_fall", 32'(o_Start), 32'h1);
    i_Conv_Done = 1'b1;
    @(negedge clk);
    chk("lvl_rise", 32'(o_Start), 32'h0);
    i_Conv_Done = 1'b0;
    chk("lvl_timeout", 32'(o_Timeout), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
